sd_cmd_resp_receiver: RTL and testbench

- Receives SD/eMMC command responses on the CMD line. It is the receive end of the SD bus, clocked by the divided sd_clk from the host clock divider.
- Runs entirely in the AXI_CLOCK domain. It samples CMD on detected sd_clk rising edges, frames a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response, checks CRC7 and framing, and reports the result to the host register block.

---
 rtl/sd_cmd_resp_receiver.sv | 150 +++++++++++++++
 tb/tb_sd_cmd_resp_receiver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_resp_receiver.sv
// SD/eMMC CMD-line response receiver: frames 48/136-bit responses sampled on sd_clk
// rising edges detected in the AXI_CLOCK domain, and checks CRC7 and end bit.
module sd_cmd_resp_receiver #(
  parameter int NCR_MAX = 64,
  parameter int TO_W    = 8
) (
  input  logic         AXI_CLOCK,
  input  logic         AXI_RST,
  input  logic         sd_clk,
  input  logic         cmd_i,
  input  logic         arm,
  input  logic         long_resp,
  input  logic         crc_en,
  output logic         busy,
  output logic         done,
  output logic [127:0] resp,
  output logic [5:0]   resp_index,
  output logic         crc_err,
  output logic         frame_err,
  output logic         timeout_err
);

  typedef enum logic [2:0] {IDLE, WAIT_START, RECV, CHECK, DONE} state_t;

  state_t          state;
  logic            sd_clk_q;
  logic            long_q;
  logic            crc_en_q;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      bit_cnt;
  logic [6:0]      crc_reg;
  logic [6:0]      rx_crc;
  logic            end_bit;
  logic            rise;

  assign rise = sd_clk & ~sd_clk_q;

  // Serial CRC7, polynomial x^7 + x^3 + 1, MSB-first
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  always_ff @(posedge AXI_CLOCK or posedge AXI_RST) begin
    if (AXI_RST) begin
      state       <= IDLE;
      sd_clk_q    <= 1'b0;
      long_q      <= 1'b0;
      crc_en_q    <= 1'b0;
      to_cnt      <= '0;
      bit_cnt     <= '0;
      crc_reg     <= '0;
      rx_crc      <= '0;
      end_bit     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      resp        <= '0;
      resp_index  <= '0;
      crc_err     <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      sd_clk_q <= sd_clk;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            long_q      <= long_resp;
            crc_en_q    <= crc_en;
            crc_err     <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            to_cnt      <= '0;
            bit_cnt     <= '0;
            busy        <= 1'b1;
            state       <= WAIT_START;
          end
        end

        WAIT_START: begin
          if (rise) begin
            if (!cmd_i) begin
              crc_reg <= crc7_step(7'd0, 1'b0);
              bit_cnt <= 8'd1;
              state   <= RECV;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
              if (to_cnt == TO_W'(NCR_MAX - 1)) begin
                timeout_err <= 1'b1;
                busy        <= 1'b0;
                done        <= 1'b1;
                state       <= DONE;
              end
            end
          end
        end

        RECV: begin
          if (rise) begin
            bit_cnt <= bit_cnt + 8'd1;
            if (long_q) begin
              // R2: header is skipped, CRC restarts on the first payload bit
              resp_index <= 6'h3F;
              if (bit_cnt >= 8'd8)
                resp <= {resp[126:0], cmd_i};
              if (bit_cnt == 8'd8)
                crc_reg <= crc7_step(7'd0, cmd_i);
              else if (bit_cnt > 8'd8 && bit_cnt <= 8'd127)
                crc_reg <= crc7_step(crc_reg, cmd_i);
              if (bit_cnt >= 8'd128 && bit_cnt <= 8'd134)
                rx_crc <= {rx_crc[5:0], cmd_i};
              if (bit_cnt == 8'd135) begin
                end_bit <= cmd_i;
                state   <= CHECK;
              end
            end else begin
              resp[127:32] <= '0;
              if (bit_cnt <= 8'd39)
                crc_reg <= crc7_step(crc_reg, cmd_i);
              if (bit_cnt >= 8'd2 && bit_cnt <= 8'd7)
                resp_index <= {resp_index[4:0], cmd_i};
              if (bit_cnt >= 8'd8 && bit_cnt <= 8'd39)
                resp[31:0] <= {resp[30:0], cmd_i};
              if (bit_cnt >= 8'd40 && bit_cnt <= 8'd46)
                rx_crc <= {rx_crc[5:0], cmd_i};
              if (bit_cnt == 8'd47) begin
                end_bit <= cmd_i;
                state   <= CHECK;
              end
            end
          end
        end

        CHECK: begin
          crc_err   <= crc_en_q && (crc_reg != rx_crc);
          frame_err <= ~end_bit;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= DONE;
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_resp_receiver.sv
// Bench for sd_cmd_resp_receiver: directed and random frames checked against a
// CRC7 long-division model and frame builder.
module tb_sd_cmd_resp_receiver;

  logic         AXI_CLOCK;
  logic         AXI_RST;
  logic         sd_clk;
  logic         cmd_i;
  logic         arm;
  logic         long_resp;
  logic         crc_en;
  logic         busy;
  logic         done;
  logic [127:0] resp;
  logic [5:0]   resp_index;
  logic         crc_err;
  logic         frame_err;
  logic         timeout_err;

  int errors = 0;
  int checks = 0;
  int half   = 2;
  logic [127:0] last_resp = '0;
  logic [5:0]   last_idx  = '0;

  sd_cmd_resp_receiver #(.NCR_MAX(64), .TO_W(8)) dut (
    .AXI_CLOCK  (AXI_CLOCK),
    .AXI_RST    (AXI_RST),
    .sd_clk     (sd_clk),
    .cmd_i      (cmd_i),
    .arm        (arm),
    .long_resp  (long_resp),
    .crc_en     (crc_en),
    .busy       (busy),
    .done       (done),
    .resp       (resp),
    .resp_index (resp_index),
    .crc_err    (crc_err),
    .frame_err  (frame_err),
    .timeout_err(timeout_err)
  );

  initial AXI_CLOCK = 1'b0;
  always #5 AXI_CLOCK = ~AXI_CLOCK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Remainder of msg(x) * x^7 divided by x^7 + x^3 + 1
  function automatic logic [6:0] crc7(input logic [127:0] msg, input int n);
    logic [134:0] r;
    r = {7'd0, msg} << 7;
    for (int i = n + 6; i >= 7; i--)
      if (r[i]) r = r ^ (135'h89 << (i - 7));
    return r[6:0];
  endfunction

  task automatic tick();
    @(posedge AXI_CLOCK);
    #1;
  endtask

  // Present one CMD bit and raise sd_clk; the rise is seen on the next AXI edge
  task automatic sd_rise(input logic b);
    if (sd_clk) repeat (half) tick();
    cmd_i  = b;
    sd_clk = 1'b0;
    repeat (half) tick();
    sd_clk = 1'b1;
  endtask

  task automatic arm_it(input logic lng, input logic ce);
    arm = 1'b1; long_resp = lng; crc_en = ce;
    tick();
    arm = 1'b0;
    chk("busy_after_arm", busy, 1'b1);
  endtask

  task automatic run_frame(input logic [135:0] f, input int len, input logic lng, input logic ce,
                           input logic [127:0] e_resp, input logic [5:0] e_idx,
                           input logic e_crc, input logic e_frm, input logic busy_arm,
                           input string tag);
    arm_it(lng, ce);
    if (busy_arm) begin
      arm = 1'b1; long_resp = ~lng;
      tick();
      arm = 1'b0;
    end
    repeat ($urandom_range(1, 8)) sd_rise(1'b1);
    for (int i = 0; i < len; i++) sd_rise(f[len-1-i]);
    tick();
    chk({tag, "_no_early_done"}, done, 1'b0);
    tick();
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    chk({tag, "_resp"}, resp, e_resp);
    chk({tag, "_index"}, resp_index, e_idx);
    chk({tag, "_crc_err"}, crc_err, e_crc);
    chk({tag, "_frame_err"}, frame_err, e_frm);
    chk({tag, "_timeout_err"}, timeout_err, 1'b0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    cmd_i = 1'b1;
    chk({tag, "_done_single"}, done, 1'b0);
    chk({tag, "_arm_at_done_ignored"}, busy, 1'b0);
    chk({tag, "_crc_err_held"}, crc_err, e_crc);
    last_resp = e_resp;
    last_idx  = e_idx;
    $display("frame %s: len=%0d div=%0d crc_en=%0b resp=%h idx=%h crc_err=%0b frame_err=%0b",
             tag, len, 2 * half, ce, e_resp, e_idx, e_crc, e_frm);
  endtask

  task automatic run_short(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] corrupt,
                           input logic endb, input logic ce, input string tag);
    logic [39:0]  h;
    logic [6:0]   rx;
    logic [135:0] f;
    h  = {2'b01, idx, arg};
    rx = crc7({88'd0, h}, 40) ^ corrupt;
    f  = {88'd0, h, rx, endb};
    run_frame(f, 48, 1'b0, ce, {96'd0, arg}, idx, ce && (corrupt != 7'd0), ~endb, 1'b0, tag);
  endtask

  task automatic run_long(input logic [119:0] payload, input logic [6:0] corrupt,
                          input logic endb, input logic ce, input string tag);
    logic [6:0]   rx;
    logic [135:0] f;
    rx = crc7({8'd0, payload}, 120) ^ corrupt;
    f  = {8'h3F, payload, rx, endb};
    run_frame(f, 136, 1'b1, ce, {payload, rx, endb}, 6'h3F, ce && (corrupt != 7'd0), ~endb,
              1'b0, tag);
  endtask

  initial begin
    logic [135:0] f;
    logic         saw_done;
    AXI_RST = 1'b1; sd_clk = 1'b0; cmd_i = 1'b1; arm = 1'b0; long_resp = 1'b0; crc_en = 1'b0;
    repeat (3) tick();
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_resp", resp, 128'd0);
    chk("reset_index", resp_index, 6'd0);
    chk("reset_errs", {crc_err, frame_err, timeout_err}, 3'b000);
    AXI_RST = 1'b0;
    tick();

    // Directed frames at divider ratio 4, the first with an arm pulse while busy
    half = 2;
    f = {88'd0, 48'h48_000001AA_87};
    run_frame(f, 48, 1'b0, 1'b1, 128'h1AA, 6'h08, 1'b0, 1'b0, 1'b1, "cmd8_ok");
    f = {88'd0, 48'h48_000001AA_85};
    run_frame(f, 48, 1'b0, 1'b1, 128'h1AA, 6'h08, 1'b1, 1'b0, 1'b0, "cmd8_badcrc");
    run_frame(f, 48, 1'b0, 1'b0, 128'h1AA, 6'h08, 1'b0, 1'b0, 1'b0, "cmd8_crc_off");
    f = {88'd0, 48'h40_00000000_94};
    run_frame(f, 48, 1'b0, 1'b1, 128'h0, 6'h00, 1'b0, 1'b1, 1'b0, "end_bit_0");

    // Timeout: no start bit for NCR_MAX rises
    arm_it(1'b0, 1'b1);
    repeat (63) sd_rise(1'b1);
    tick();
    chk("to_no_early_done", done, 1'b0);
    chk("to_still_busy", busy, 1'b1);
    sd_rise(1'b1);
    tick();
    chk("to_done", done, 1'b1);
    chk("to_timeout_err", timeout_err, 1'b1);
    chk("to_other_errs", {crc_err, frame_err}, 2'b00);
    chk("to_resp_held", resp, last_resp);
    chk("to_index_held", resp_index, last_idx);
    tick();
    chk("to_done_single", done, 1'b0);
    $display("frame timeout: rises=64 timeout_err=1 resp=%h", last_resp);

    // R2 at divide-by-2
    half = 1;
    run_long(120'h0102030405060708090A0B0C0D0E0F, 7'd0, 1'b1, 1'b1, "r2_div2");

    // Reset in the middle of a frame, then a clean frame
    half = 2;
    arm_it(1'b0, 1'b1);
    repeat (3) sd_rise(1'b1);
    f = {88'd0, 48'h48_000001AA_87};
    for (int i = 0; i < 20; i++) sd_rise(f[47-i]);
    tick();
    AXI_RST = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_resp", resp, 128'd0);
    chk("rst_mid_index", resp_index, 6'd0);
    chk("rst_mid_errs", {done, crc_err, frame_err, timeout_err}, 4'b0000);
    repeat (2) tick();
    AXI_RST = 1'b0;
    saw_done = 1'b0;
    repeat (10) begin tick(); saw_done |= done; end
    chk("rst_no_spurious_done", saw_done, 1'b0);
    $display("frame reset_mid: aborted at bit 20");
    run_frame(f, 48, 1'b0, 1'b1, 128'h1AA, 6'h08, 1'b0, 1'b0, 1'b0, "after_reset");

    // Stopped sd_clk: no rises, no timeout
    arm_it(1'b0, 1'b1);
    saw_done = 1'b0;
    repeat (300) begin tick(); saw_done |= done; end
    chk("stopped_no_done", saw_done, 1'b0);
    chk("stopped_busy", busy, 1'b1);
    AXI_RST = 1'b1;
    tick();
    AXI_RST = 1'b0;
    chk("stopped_recover", busy, 1'b0);
    last_resp = '0;
    last_idx  = '0;
    $display("frame stopped_clk: held busy 300 cycles, recovered by reset");

    // Random frames
    for (int n = 0; n < 10; n++) begin
      logic [6:0] corrupt;
      logic       endb;
      logic       ce;
      half    = $urandom_range(1, 4);
      corrupt = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
      endb    = ($urandom_range(0, 3) != 0);
      ce      = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1)
        run_long({$urandom, $urandom, $urandom, 24'($urandom)}, corrupt, endb, ce, "rand_r2");
      else
        run_short(6'($urandom), $urandom, corrupt, endb, ce, "rand_short");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
